// File: rtl/seq_mult_shift_add_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// abs_w works on a fixed 32-bit container so one definition serves every WIDTH.
`timescale 1ns/1ps
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Magnitude of a width-bit value; the most negative value maps to 2^(width-1).
  function automatic logic [MAX_WIDTH-1:0] abs_w(
    input logic [MAX_WIDTH-1:0] value,
    input int                   width,
    input logic                 signed_mode
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] v;
    mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    v    = value & mask;
    if (signed_mode && v[5'(width - 1)]) begin
      return (~v + MAX_WIDTH'(1)) & mask;
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Operand/product handshake bundle for seq_mult_shift_add.
`timescale 1ns/1ps
interface seq_mult_shift_add_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     m_in;
  logic [WIDTH-1:0]     q_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, signed_mode, m_in, q_in, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, signed_mode, m_in, q_in, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mult_shift_add_sign_fix.sv
// Applies the result sign to the unsigned magnitude product {A,Q}.
`timescale 1ns/1ps
module seq_mult_sign_fix #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] ab,
  input  logic               neg,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] product
);
  assign product = (neg & signed_mode) ? -ab : ab;
endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier: one partial-product step per clock,
// signed operands handled as magnitudes with the sign restored at the end.
`timescale 1ns/1ps
module seq_mult_shift_add
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_mult_shift_add_if.slave  bus
);

  state_t             state_reg;
  logic [WIDTH-1:0]   m_reg;
  logic               c_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               neg_reg;
  logic               mode_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH:0]     sum;
  logic               c_next;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   q_next;
  logic [2*WIDTH-1:0] fixed;
  logic               last;

  // Conditional add into {C,A}, then shift {C,A,Q} right with a zero in.
  always_comb begin
    sum    = q_reg[0] ? ({1'b0, a_reg} + {1'b0, m_reg}) : {c_reg, a_reg};
    {c_next, a_next, q_next} = {1'b0, sum, q_reg[WIDTH-1:1]};
    last   = (count_reg == CNT_W'(WIDTH - 1));
  end

  seq_mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .ab          ({a_next, q_next}),
    .neg         (neg_reg),
    .signed_mode (mode_reg),
    .product     (fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      m_reg         <= '0;
      c_reg         <= 1'b0;
      a_reg         <= '0;
      q_reg         <= '0;
      count_reg     <= '0;
      neg_reg       <= 1'b0;
      mode_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            mode_reg     <= bus.signed_mode;
            neg_reg      <= bus.m_in[WIDTH-1] ^ bus.q_in[WIDTH-1];
            m_reg        <= WIDTH'(abs_w(MAX_WIDTH'(bus.m_in), WIDTH, bus.signed_mode));
            q_reg        <= WIDTH'(abs_w(MAX_WIDTH'(bus.q_in), WIDTH, bus.signed_mode));
            c_reg        <= 1'b0;
            a_reg        <= '0;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          c_reg     <= c_next;
          a_reg     <= a_next;
          q_reg     <= q_next;
          count_reg <= count_reg + CNT_W'(1);
          if (last) begin
            product_reg   <= fixed;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the output handshake edge, never alongside it.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: WIDTH=4 directed cases and WIDTH=8 random ops.
`timescale 1ns/1ps
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_shift_add_if #(.WIDTH(4)) if4 ();
  seq_mult_shift_add_if #(.WIDTH(8)) if8 ();

  seq_mult_shift_add #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  seq_mult_shift_add #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp4[$];
  logic [63:0] exp8[$];
  bit rnd8 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: plain integer multiplication of the operands' numeric values.
  function automatic logic [63:0] ref_mult(input logic [31:0] m, input logic [31:0] q,
                                           input logic sm, input int w);
    longint a, b;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    a = longint'(m);
    b = longint'(q);
    if (sm) begin
      if (((m >> (w - 1)) & 32'd1) != 0) a = a - (longint'(1) << w);
      if (((q >> (w - 1)) & 32'd1) != 0) b = b - (longint'(1) << w);
    end
    return 64'(a * b) & mask;
  endfunction

  task automatic issue(input int w, input logic [31:0] m, input logic [31:0] q,
                       input logic sm, input bit push);
    int n = 0;
    @(negedge clk);
    while (!(w == 4 ? if4.in_ready : if8.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("in_ready_timeout");
    if (w == 4) begin
      if4.in_valid = 1'b1; if4.m_in = m[3:0]; if4.q_in = q[3:0]; if4.signed_mode = sm;
      if (push) exp4.push_back(ref_mult(m, q, sm, 4));
    end else begin
      if8.in_valid = 1'b1; if8.m_in = m[7:0]; if8.q_in = q[7:0]; if8.signed_mode = sm;
      if (push) exp8.push_back(ref_mult(m, q, sm, 8));
    end
    $display("issue w=%0d m=0x%0h q=0x%0h signed=%0d", w, m, q, sm);
    @(posedge clk);
    #1;
    // Operand inputs are don't-care once the operation is running.
    if4.in_valid = 1'b0; if4.m_in = 4'($urandom); if4.q_in = 4'($urandom); if4.signed_mode = 1'($urandom);
    if8.in_valid = 1'b0; if8.m_in = 8'($urandom); if8.q_in = 8'($urandom); if8.signed_mode = 1'($urandom);
  endtask

  task automatic wait_out(input int w, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(w == 4 ? if4.out_valid : if8.out_valid) && lat < 100);
  endtask

  task automatic wait_idle(input int w);
    int n = 0;
    while ((w == 4 ? if4.out_valid : if8.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("out_handshake_timeout");
  endtask

  task automatic run_op(input int w, input logic [31:0] m, input logic [31:0] q, input logic sm);
    int lat;
    issue(w, m, q, sm, 1'b1);
    wait_out(w, lat);
    check("latency", 64'(lat), 64'(w + 1));
    wait_idle(w);
  endtask

  // Monitors: compare every presented product with the queue head, pop on handshake.
  initial begin : mon4
    bit hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) hs = 1'b0;
      else begin
        if (hs) begin check("w4_in_ready_after_out", 64'(if4.in_ready), 64'd1); hs = 1'b0; end
        if (if4.out_valid) begin
          check("w4_in_ready_in_done", 64'(if4.in_ready), 64'd0);
          if (exp4.size() == 0) fail("w4_unexpected_output");
          else begin
            check("w4_product", 64'(if4.product), exp4[0]);
            if (if4.out_ready) begin
              $display("out w=4 product=0x%0h", if4.product);
              void'(exp4.pop_front());
              hs = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : mon8
    bit hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) hs = 1'b0;
      else begin
        if (hs) begin check("w8_in_ready_after_out", 64'(if8.in_ready), 64'd1); hs = 1'b0; end
        if (if8.out_valid) begin
          check("w8_in_ready_in_done", 64'(if8.in_ready), 64'd0);
          if (exp8.size() == 0) fail("w8_unexpected_output");
          else begin
            check("w8_product", 64'(if8.product), exp8[0]);
            if (if8.out_ready) begin
              $display("out w=8 product=0x%0h", if8.product);
              void'(exp8.pop_front());
              hs = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd8) if8.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] e;
    int lat;
    if4.in_valid = 1'b0; if4.m_in = '0; if4.q_in = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.m_in = '0; if8.q_in = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready4", 64'(if4.in_ready), 64'd1);
    check("rst_out_valid4", 64'(if4.out_valid), 64'd0);
    check("rst_product4", 64'(if4.product), 64'd0);
    check("rst_in_ready8", 64'(if8.in_ready), 64'd1);
    check("rst_out_valid8", 64'(if8.out_valid), 64'd0);
    check("rst_product8", 64'(if8.product), 64'd0);

    run_op(4, 32'hD, 32'hB, 1'b0);
    run_op(4, 32'hF, 32'hF, 1'b0);
    run_op(4, 32'h0, 32'h9, 1'b0);
    run_op(4, 32'hD, 32'h5, 1'b1);
    run_op(4, 32'h8, 32'h8, 1'b1);
    run_op(4, 32'h0, 32'hB, 1'b1);

    // Backpressure: hold the 6x7 result for several stalled cycles.
    if4.out_ready = 1'b0;
    e = ref_mult(32'd6, 32'd7, 1'b0, 4);
    issue(4, 32'd6, 32'd7, 1'b0, 1'b1);
    wait_out(4, lat);
    check("bp_latency", 64'(lat), 64'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(if4.out_valid), 64'd1);
      check("bp_product", 64'(if4.product), e);
      check("bp_in_ready", 64'(if4.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 if4.out_ready = 1'b1;
    wait_idle(4);

    // Reset two edges into a 9x9 aborts it without any output.
    issue(4, 32'd9, 32'd9, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(if4.out_valid), 64'd0);
    check("abort_in_ready", 64'(if4.in_ready), 64'd1);
    check("abort_product", 64'(if4.product), 64'd0);
    repeat (8) @(negedge clk);
    run_op(4, 32'd2, 32'd3, 1'b0);

    // WIDTH=8: corner cases, then random mixed-mode ops with random out_ready stalls.
    rnd8 = 1'b1;
    run_op(8, 32'h80, 32'h80, 1'b1);
    run_op(8, 32'hFF, 32'hFF, 1'b0);
    run_op(8, 32'hFF, 32'hFF, 1'b1);
    run_op(8, 32'h80, 32'h01, 1'b1);
    run_op(8, 32'h00, 32'h55, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
    end
    rnd8 = 1'b0;
    @(posedge clk);
    #1 if8.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    check("w4_queue_drained", 64'(exp4.size()), 64'd0);
    check("w8_queue_drained", 64'(exp8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
# seq_mult_shift_add

Parametrised, clocked shift-and-add multiplier. It computes one partial-product step per clock over a WIDTH-cycle iteration and supports both unsigned and signed (two's-complement) operands, selected per operation. It replaces the combinational unrolled 4-bit multiplier in the arithmetic datapath. Operands enter and the product leaves through valid/ready handshakes, so the block slots between pipeline stages with backpressure.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operation.
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned. Sampled with the operands.
- m_in  input  WIDTH  multiplicand.
- q_in  input  WIDTH  multiplier.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result; two's complement when signed_mode was 1.

## Operation
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) captures the operands and moves to RUN.
  - RUN: WIDTH iterations. After the last iteration, moves to DONE.
  - DONE: out_valid=1. The state returns to IDLE on out_ready.
- Capture:
  - In unsigned mode, M and Q are stored as given.
  - In signed mode, the magnitudes |m_in| and |q_in| are stored as WIDTH-bit unsigned values. The flag neg = m_in[MSB] ^ q_in[MSB] is stored.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. No overflow.
- Accumulator register {C, A, Q} is 2*WIDTH+1 bits. At capture: C=0, A=0, Q=multiplier magnitude, count=0.
- Each RUN cycle:
  - If Q[0]=1, {C,A} = A + M (carry kept in C).
  - Then {C,A,Q} is shifted right by 1, with 0 into the MSB.
  - count increments.
- Leaving RUN: after the step where count reaches WIDTH-1, the product register loads {A,Q}, two's-complement negated if (signed_mode & neg).
- Values stay stable in DONE:
  - product holds its value from the DONE-entry edge until the output handshake.
  - product is unchanged in IDLE, holding the last result.
- No overlap: in_ready=0 in RUN and DONE. This also holds in the DONE cycle where out_ready=1. A new operation is accepted no earlier than the cycle after the output handshake.
- Input-side values are ignored outside IDLE: in_valid, m_in, q_in and signed_mode are don't-care in RUN and DONE.
- Reset:
  - Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, accumulator=0, count=0.
  - Reset asserted mid-RUN or in DONE aborts the operation. No product is emitted.
- Zero operand: the full WIDTH cycles still run; the result is 0. In signed mode a negated 0 is still 0.

## Timing
- E0 is the clock edge at which the input handshake occurs.
- Edges E0+1 .. E0+WIDTH perform the WIDTH iterations. State becomes DONE at edge E0+WIDTH.
- out_valid is high in the cycle after edge E0+WIDTH. Latency from input handshake to out_valid is WIDTH+1 cycles.
- If out_ready is high in the first DONE cycle, state=IDLE after the next edge. The minimum initiation interval is WIDTH+2 cycles.
- out_valid stays high and product stays stable for any number of stall cycles while out_ready=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package seq_mult_pkg:
  - state enum {IDLE, RUN, DONE}.
  - a function abs_w(value, signed_mode) returning the WIDTH-bit magnitude.
- One sub-module is natural: seq_mult_sign_fix. It is combinational and takes {A,Q}, neg and signed_mode, producing the final 2*WIDTH product.
- The FSM, accumulator and counter live in the top module.

## Test plan
- W=4, unsigned 13×11 (0xD, 0xB) -> product 0x008F (143) at E0+5; carry bit exercised.
- W=4, unsigned 15×15 -> 0x00E1 (225). Also 0×9 -> 0x0000 after the full 4 iterations.
- W=4, signed_mode=1: -3×5 (0xD, 0x5) -> 0xF1 (-15). Also -8×-8 (0x8, 0x8) -> 0x40 (64).
- Backpressure: complete 6×7 with out_ready=0 for 5 cycles -> out_valid and 0x2A held stable. in_ready stays 0 until the cycle after the handshake.
- Reset at E0+2 during 9×9 -> next cycle out_valid=0, in_ready=1, product=0. A following 2×3 -> 0x06.
- WIDTH=8, randomised back-to-back ops in both modes vs. a reference model. Check latency is 9 cycles and in_ready gaps are as specified.
